// File: rtl/data_memory_controller_if.sv
// Memory-stage request/response and external bus signals for data_memory_controller.
// The slave modport is the controller's view; the master modport is the requester/bus model.
interface data_memory_controller_if;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [3:0]  byte_enable;
    logic        store_valid;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_data_valid;
    logic        store_complete;
    logic        access_fault;
    logic        busy;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_write;
    logic        bus_request;
    logic        bus_ready;
    logic [31:0] bus_read_data;

    modport slave (
        input  address, store_data, byte_enable, store_valid, load_valid,
        input  bus_ready, bus_read_data,
        output load_data, load_data_valid, store_complete, access_fault, busy,
        output bus_address, bus_write_data, bus_byte_enable, bus_write, bus_request
    );

    modport master (
        output address, store_data, byte_enable, store_valid, load_valid,
        output bus_ready, bus_read_data,
        input  load_data, load_data_valid, store_complete, access_fault, busy,
        input  bus_address, bus_write_data, bus_byte_enable, bus_write, bus_request
    );
endinterface

// File: rtl/data_memory_controller.sv
// Single-outstanding load/store controller between the Memory stage and an external bus.
// Optional bus timeout abort is enabled by defining DMEM_TIMEOUT_EN.
module data_memory_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    data_memory_controller_if.slave  mem_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_any_req;
    logic        w_accept;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_next_store;
    logic        w_next_fault;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_is_store;
    logic        r_fault;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_store_complete;
    logic        r_access_fault;
    logic        r_busy;
    logic        r_bus_request;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 2..255");
        end
    endgenerate

    assign w_any_req    = mem_if.store_valid | mem_if.load_valid;
    assign w_misaligned = (mem_if.address[1:0] != 2'b00);

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_timeout_count;

    // Counts busReady-low cycles of the current bus request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timeout_count <= 8'd0;
        end else if (w_next_state == REQUEST && r_state != REQUEST) begin
            r_timeout_count <= 8'd0;
        end else if (r_state == REQUEST && !mem_if.bus_ready) begin
            r_timeout_count <= r_timeout_count + 8'd1;
        end else begin
            r_timeout_count <= r_timeout_count;
        end
    end

    // Abort in the cycle that would be the TIMEOUT_CYCLES-th unanswered one.
    assign w_timeout = (r_state == REQUEST) && !mem_if.bus_ready &&
                       (r_timeout_count == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a simultaneous load is dropped in favour of the store.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_accept = 1'b1;
                    if (w_misaligned) begin
                        w_next_state = RESPOND;
                    end else if (mem_if.store_valid && mem_if.byte_enable == 4'b0000) begin
                        w_next_state = RESPOND;
                    end else begin
                        w_next_state = REQUEST;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            REQUEST: begin
                if (mem_if.bus_ready || w_timeout) begin
                    w_next_state = RESPOND;
                end else begin
                    w_next_state = REQUEST;
                end
            end
            RESPOND: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        w_next_store = w_accept ? mem_if.store_valid : r_is_store;
        w_next_fault = w_accept ? w_misaligned : (r_fault | w_timeout);
    end

    // Request capture, load result and registered status/pulse outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr           <= 32'h0000_0000;
            r_wdata          <= 32'h0000_0000;
            r_be             <= 4'h0;
            r_is_store       <= 1'b0;
            r_fault          <= 1'b0;
            r_load_data      <= 32'h0000_0000;
            r_load_valid     <= 1'b0;
            r_store_complete <= 1'b0;
            r_access_fault   <= 1'b0;
            r_busy           <= 1'b0;
            r_bus_request    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= {mem_if.address[31:2], 2'b00};
                r_wdata    <= mem_if.store_valid ? mem_if.store_data : 32'h0000_0000;
                r_be       <= mem_if.store_valid ? mem_if.byte_enable : 4'hF;
                r_is_store <= mem_if.store_valid;
            end
            r_fault <= w_next_fault;
            if (r_state == REQUEST && mem_if.bus_ready && !r_is_store) begin
                r_load_data <= mem_if.bus_read_data;
            end else if (w_next_state == RESPOND && w_next_fault && !w_next_store) begin
                r_load_data <= 32'h0000_0000;
            end
            r_busy           <= (w_next_state != IDLE);
            r_bus_request    <= (w_next_state == REQUEST);
            r_load_valid     <= (w_next_state == RESPOND) && !w_next_store;
            r_store_complete <= (w_next_state == RESPOND) && w_next_store;
            r_access_fault   <= (w_next_state == RESPOND) && w_next_fault;
        end
    end

    assign mem_if.load_data       = r_load_data;
    assign mem_if.load_data_valid = r_load_valid;
    assign mem_if.store_complete  = r_store_complete;
    assign mem_if.access_fault    = r_access_fault;
    assign mem_if.busy            = r_busy;
    assign mem_if.bus_address     = r_addr;
    assign mem_if.bus_write_data  = r_wdata;
    assign mem_if.bus_byte_enable = r_be;
    assign mem_if.bus_write       = r_is_store;
    assign mem_if.bus_request     = r_bus_request;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed self-checking bench for data_memory_controller (TIMEOUT_CYCLES = 4).
// The timeout scenario follows DMEM_TIMEOUT_EN: abort when defined, indefinite wait otherwise.
module tb_data_memory_controller;

    logic clk = 1'b0;
    logic rst;
    int   n_checks   = 0;
    int   n_failures = 0;

    always #5 clk = ~clk;

    data_memory_controller_if mif();

    data_memory_controller #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .mem_if (mif)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives a strobe for the cycle ending at the next rising edge; returns at the following falling edge.
    task automatic issue(input logic st, input logic ld, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        mif.store_valid = st;
        mif.load_valid  = ld;
        mif.address     = a;
        mif.store_data  = d;
        mif.byte_enable = be;
        @(negedge clk);
        mif.store_valid = 1'b0;
        mif.load_valid  = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        mif.address       = 32'h0;
        mif.store_data    = 32'h0;
        mif.byte_enable   = 4'h0;
        mif.store_valid   = 1'b0;
        mif.load_valid    = 1'b0;
        mif.bus_ready     = 1'b0;
        mif.bus_read_data = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_bus_request", {31'd0, mif.bus_request}, 32'd0);
        check_eq("rst_busy", {31'd0, mif.busy}, 32'd0);
        check_eq("rst_load_data", mif.load_data, 32'h0);
        check_eq("rst_bus_address", mif.bus_address, 32'h0);
        rst = 1'b0;

        // Load with immediate ready, issued right after reset release.
        mif.bus_ready     = 1'b1;
        mif.bus_read_data = 32'hCAFE_F00D;
        issue(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        check_eq("ld_n1_req", {31'd0, mif.bus_request}, 32'd1);
        check_eq("ld_n1_addr", mif.bus_address, 32'h0000_0100);
        check_eq("ld_n1_be", {28'd0, mif.bus_byte_enable}, 32'hF);
        check_eq("ld_n1_write", {31'd0, mif.bus_write}, 32'd0);
        check_eq("ld_n1_valid", {31'd0, mif.load_data_valid}, 32'd0);
        @(negedge clk);
        check_eq("ld_n2_valid", {31'd0, mif.load_data_valid}, 32'd1);
        check_eq("ld_n2_data", mif.load_data, 32'hCAFE_F00D);
        check_eq("ld_n2_fault", {31'd0, mif.access_fault}, 32'd0);
        mif.bus_ready = 1'b0;
        @(negedge clk);
        check_eq("ld_n3_valid", {31'd0, mif.load_data_valid}, 32'd0);
        check_eq("ld_n3_busy", {31'd0, mif.busy}, 32'd0);

        // Store with ready delayed three cycles.
        issue(1'b1, 1'b0, 32'h0000_0104, 32'h1234_5678, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            check_eq("st_req", {31'd0, mif.bus_request}, 32'd1);
            check_eq("st_addr", mif.bus_address, 32'h0000_0104);
            check_eq("st_wdata", mif.bus_write_data, 32'h1234_5678);
            check_eq("st_be", {28'd0, mif.bus_byte_enable}, 32'h3);
            check_eq("st_write", {31'd0, mif.bus_write}, 32'd1);
            check_eq("st_early_cmp", {31'd0, mif.store_complete}, 32'd0);
            if (i == 3) mif.bus_ready = 1'b1;
            @(negedge clk);
        end
        check_eq("st_n5_cmp", {31'd0, mif.store_complete}, 32'd1);
        check_eq("st_n5_fault", {31'd0, mif.access_fault}, 32'd0);
        check_eq("st_n5_ldvalid", {31'd0, mif.load_data_valid}, 32'd0);
        mif.bus_ready = 1'b0;
        @(negedge clk);
        check_eq("st_n6_cmp", {31'd0, mif.store_complete}, 32'd0);
        check_eq("st_n6_busy", {31'd0, mif.busy}, 32'd0);

        // Misaligned load faults without touching the bus.
        mif.bus_ready = 1'b1;
        issue(1'b0, 1'b1, 32'h0000_0102, 32'h0, 4'h0);
        check_eq("mis_n1_req", {31'd0, mif.bus_request}, 32'd0);
        check_eq("mis_n1_valid", {31'd0, mif.load_data_valid}, 32'd1);
        check_eq("mis_n1_fault", {31'd0, mif.access_fault}, 32'd1);
        check_eq("mis_n1_data", mif.load_data, 32'h0);
        @(negedge clk);
        check_eq("mis_n2_req", {31'd0, mif.bus_request}, 32'd0);
        check_eq("mis_n2_fault", {31'd0, mif.access_fault}, 32'd0);

        // Store and load together: store wins, load gets no response.
        issue(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
        check_eq("both_n1_write", {31'd0, mif.bus_write}, 32'd1);
        check_eq("both_n1_req", {31'd0, mif.bus_request}, 32'd1);
        @(negedge clk);
        check_eq("both_n2_cmp", {31'd0, mif.store_complete}, 32'd1);
        check_eq("both_n2_ldvalid", {31'd0, mif.load_data_valid}, 32'd0);
        mif.bus_ready = 1'b0;
        @(negedge clk);
        check_eq("both_n3_ldvalid", {31'd0, mif.load_data_valid}, 32'd0);
        check_eq("both_n3_busy", {31'd0, mif.busy}, 32'd0);

        // Store with no byte lanes completes without a bus access.
        issue(1'b1, 1'b0, 32'h0000_0204, 32'h1111_1111, 4'h0);
        check_eq("be0_cmp", {31'd0, mif.store_complete}, 32'd1);
        check_eq("be0_fault", {31'd0, mif.access_fault}, 32'd0);
        check_eq("be0_req", {31'd0, mif.bus_request}, 32'd0);
        @(negedge clk);

        // Strobe arriving while busy is ignored.
        issue(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
        mif.store_valid = 1'b1;
        mif.address     = 32'h0000_0400;
        mif.byte_enable = 4'hF;
        @(negedge clk);
        mif.store_valid = 1'b0;
        check_eq("busy_addr", mif.bus_address, 32'h0000_0300);
        check_eq("busy_write", {31'd0, mif.bus_write}, 32'd0);
        mif.bus_ready     = 1'b1;
        mif.bus_read_data = 32'h0BAD_BEEF;
        @(negedge clk);
        check_eq("busy_ldvalid", {31'd0, mif.load_data_valid}, 32'd1);
        check_eq("busy_lddata", mif.load_data, 32'h0BAD_BEEF);
        check_eq("busy_cmp", {31'd0, mif.store_complete}, 32'd0);
        mif.bus_ready = 1'b0;
        @(negedge clk);
        check_eq("busy_after_cmp", {31'd0, mif.store_complete}, 32'd0);
        check_eq("busy_after_busy", {31'd0, mif.busy}, 32'd0);

        // Bus never answers.
        issue(1'b1, 1'b0, 32'h0000_0500, 32'hA5A5_A5A5, 4'hF);
`ifdef DMEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check_eq("to_req_held", {31'd0, mif.bus_request}, 32'd1);
            @(negedge clk);
        end
        check_eq("to_req_drop", {31'd0, mif.bus_request}, 32'd0);
        check_eq("to_cmp", {31'd0, mif.store_complete}, 32'd1);
        check_eq("to_fault", {31'd0, mif.access_fault}, 32'd1);
        @(negedge clk);
`else
        for (int i = 0; i < 20; i++) begin
            check_eq("wait_req_held", {31'd0, mif.bus_request}, 32'd1);
            @(negedge clk);
        end
        mif.bus_ready = 1'b1;
        @(negedge clk);
        check_eq("wait_cmp", {31'd0, mif.store_complete}, 32'd1);
        check_eq("wait_fault", {31'd0, mif.access_fault}, 32'd0);
        mif.bus_ready = 1'b0;
        @(negedge clk);
`endif

        // Reset asserted mid-request, then a normal load.
        issue(1'b0, 1'b1, 32'h0000_0600, 32'h0, 4'h0);
        check_eq("rr_req_before", {31'd0, mif.bus_request}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rr_req_async", {31'd0, mif.bus_request}, 32'd0);
        check_eq("rr_busy_async", {31'd0, mif.busy}, 32'd0);
        @(negedge clk);
        check_eq("rr_load_data", mif.load_data, 32'h0);
        rst               = 1'b0;
        mif.bus_ready     = 1'b1;
        mif.bus_read_data = 32'h55AA_33CC;
        issue(1'b0, 1'b1, 32'h0000_0700, 32'h0, 4'h0);
        check_eq("rr_n1_req", {31'd0, mif.bus_request}, 32'd1);
        @(negedge clk);
        check_eq("rr_n2_valid", {31'd0, mif.load_data_valid}, 32'd1);
        check_eq("rr_n2_data", mif.load_data, 32'h55AA_33CC);
        check_eq("rr_n2_fault", {31'd0, mif.access_fault}, 32'd0);
        mif.bus_ready = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of busReady-low cycles in REQUEST before abort (range 2..255).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 address  input  32  byte address from the Memory stage.
REQ-005 storeData  input  32  store write data.
REQ-006 byteEnable  input  4  store byte lanes.
REQ-007 storeValid  input  1  store request strobe.
REQ-008 loadValid  input  1  load request strobe.
REQ-009 loadData  output  32  registered load result.
REQ-010 loadDataValid  output  1  one-cycle load-complete pulse.
REQ-011 storeComplete  output  1  one-cycle store-complete pulse.
REQ-012 accessFault  output  1  one-cycle fault pulse, coincident with the completion pulse.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 busAddress  output  32  word-aligned external address.
REQ-015 busWriteData  output  32  external write data.
REQ-016 busByteEnable  output  4  external byte lanes; 4'hF for loads.
REQ-017 busWrite  output  1  1 = write, 0 = read.
REQ-018 busRequest  output  1  external request, held until accepted.
REQ-019 busReady  input  1  external accept; read data is valid in the same cycle.
REQ-020 busReadData  input  32  external read data.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, REQUEST and RESPOND.
REQ-022 In IDLE, a strobe SHALL be accepted only when busy is low, and address, data, byte enables and type SHALL be captured into registers.
REQ-023 If storeValid and loadValid are both high in the same cycle, the store SHALL be accepted and the load SHALL be dropped with no response.
REQ-024 If an accepted request has address[1:0] != 0, the FSM SHALL go to RESPOND with a fault flag set, and busRequest SHALL never assert for that request.
REQ-025 An accepted store with byteEnable == 0 SHALL go directly to RESPOND with no fault and no bus access.
REQ-026 All other accepted requests SHALL enter REQUEST, where busRequest = 1 and bus fields are driven from the captured registers.
REQ-027 In REQUEST, busRequest and all bus fields SHALL stay stable until busReady is sampled high.
REQ-028 On the busReady handshake, a load SHALL register busReadData into loadData, and the FSM SHALL enter RESPOND.
REQ-029 RESPOND SHALL last exactly one cycle, pulse exactly one of loadDataValid or storeComplete, and pulse accessFault if the fault flag is set.
REQ-030 RESPOND SHALL always return to IDLE, and a new request SHALL be accepted no earlier than that following IDLE cycle.
REQ-031 Minimum latency SHALL be: request sampled in cycle N, busRequest high in N+1, completion pulse in N+2 when busReady is high in N+1.
REQ-032 For faulted requests, latency SHALL be: request in N, pulse in N+1.
REQ-033 loadData SHALL hold its last value except when updated by a load handshake, and SHALL be forced to 0 on a faulted load.
REQ-034 Strobes arriving while busy is high SHALL be ignored.

Reset
REQ-035 While reset is high, the FSM SHALL be in IDLE and all outputs and internal registers SHALL be 0, including mid-transaction, where busRequest SHALL drop immediately.
REQ-036 After reset deasserts, the first request SHALL be accepted on the next rising clock edge.

Configuration
REQ-037 With DMEM_TIMEOUT_EN defined, an 8-bit counter SHALL count busReady-low cycles in REQUEST and clear on entry to REQUEST.
REQ-038 With DMEM_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES, busRequest SHALL drop and the FSM SHALL enter RESPOND with the fault flag set; a faulted load SHALL return loadData = 0.
REQ-039 Without DMEM_TIMEOUT_EN, no counter SHALL exist and REQUEST SHALL wait for busReady indefinitely.

Verification
REQ-040 Bench SHALL apply a load to 0x100 with busReady high immediately and busReadData = 0xCAFEF00D, and SHALL check loadData = 0xCAFEF00D with loadDataValid in N+2 and no accessFault.
REQ-041 Bench SHALL apply a store to 0x104 with data 0x12345678, byteEnable 4'b0011 and busReady delayed 3 cycles, and SHALL check that bus fields are stable for 4 cycles and that storeComplete pulses once, in N+5.
REQ-042 Bench SHALL apply a load to 0x102, and SHALL check that busRequest is never asserted, that accessFault and loadDataValid pulse in N+1, and that loadData = 0.
REQ-043 Bench SHALL assert storeValid and loadValid together, and SHALL check that busWrite = 1 and that only storeComplete pulses.
REQ-044 Bench SHALL build with DMEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4 and busReady held low, and SHALL check that busRequest drops after 4 cycles and that accessFault pulses with storeComplete.
REQ-045 Bench SHALL assert reset during REQUEST, and SHALL check that busRequest and busy are 0 before the next clock edge and that a subsequent load completes normally.
